// File: rtl/perf_watch.sv
// perf_watch -- per-channel start/done latency monitor with a burst launcher.
//
// Each of NCH channels measures the cycles from a start edge to a done edge.
// The channel keeps last/max/min latency and a count of completed measurements,
// plus sticky overrun and timeout flags. A small burst engine issues burst_num
// one-cycle kick pulses to one channel and waits for that channel's done edge
// after each kick before issuing the next one.
//
// Build option: define PERF_WATCH_TIMEOUT_EN to include the timeout detector.
// When it is not defined, timeout_flag is constant 0 and timeout_lim is ignored.
//
// Ports
//   ap_clk        clock, all logic on the rising edge
//   ap_rst        asynchronous active-high reset
//   ap_start[n]   per-channel start level (asynchronous, synchronised here)
//   ap_done[n]    per-channel done level (asynchronous, synchronised here)
//   burst_go      burst request level; a rising edge starts a burst
//   burst_num     kicks per burst, captured when a burst is accepted
//   burst_ch      target channel of the burst, captured with burst_num
//   clr           synchronous clear of statistics, flags and burst engine
//   timeout_lim   timeout threshold in cycles, 0 disables the timeout
//   rd_ch         channel shown on the registered statistics outputs
//   kick[n]       one-cycle launch pulse
//   busy          burst engine not idle
//   lat_last/lat_max/lat_min/done_cnt  statistics of channel rd_ch
//   timeout_flag/overrun_flag          sticky per-channel flags
module perf_watch #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int NW  = 16
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst,
    input  logic [NCH-1:0]                       ap_start,
    input  logic [NCH-1:0]                       ap_done,
    input  logic                                 burst_go,
    input  logic [NW-1:0]                        burst_num,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] burst_ch,
    input  logic                                 clr,
    input  logic [CW-1:0]                        timeout_lim,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
    output logic [NCH-1:0]                       kick,
    output logic                                 busy,
    output logic [CW-1:0]                        lat_last,
    output logic [CW-1:0]                        lat_max,
    output logic [CW-1:0]                        lat_min,
    output logic [CW-1:0]                        done_cnt,
    output logic [NCH-1:0]                       timeout_flag,
    output logic [NCH-1:0]                       overrun_flag
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Synchroniser chains: stage0 absorbs metastability, stage1/stage2 give the edge.
    logic [NCH-1:0] st_s0_q, st_s1_q, st_s2_q;
    logic [NCH-1:0] dn_s0_q, dn_s1_q, dn_s2_q;
    logic           go_s0_q, go_s1_q, go_s2_q;
    logic [NCH-1:0] start_e, done_e;
    logic           go_e;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            st_s0_q <= '0;
            st_s1_q <= '0;
            st_s2_q <= '0;
            dn_s0_q <= '0;
            dn_s1_q <= '0;
            dn_s2_q <= '0;
            go_s0_q <= 1'b0;
            go_s1_q <= 1'b0;
            go_s2_q <= 1'b0;
        end else begin
            st_s0_q <= ap_start;
            st_s1_q <= st_s0_q;
            st_s2_q <= st_s1_q;
            dn_s0_q <= ap_done;
            dn_s1_q <= dn_s0_q;
            dn_s2_q <= dn_s1_q;
            go_s0_q <= burst_go;
            go_s1_q <= go_s0_q;
            go_s2_q <= go_s1_q;
        end
    end

    assign start_e = st_s1_q & ~st_s2_q;
    assign done_e  = dn_s1_q & ~dn_s2_q;
    assign go_e    = go_s1_q & ~go_s2_q;

    // Per-channel measurement state and statistics.
    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [CW-1:0]  last_q [NCH];
    logic [CW-1:0]  last_d [NCH];
    logic [CW-1:0]  max_q  [NCH];
    logic [CW-1:0]  max_d  [NCH];
    logic [CW-1:0]  min_q  [NCH];
    logic [CW-1:0]  min_d  [NCH];
    logic [CW-1:0]  dcnt_q [NCH];
    logic [CW-1:0]  dcnt_d [NCH];
    logic [NCH-1:0] run_q, run_d;
    logic [NCH-1:0] ovr_q, ovr_d;
    logic [NCH-1:0] to_q, to_d;

`ifndef PERF_WATCH_TIMEOUT_EN
    logic unused_timeout_lim;
    assign unused_timeout_lim = ^timeout_lim;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        max_d  = max_q;
        min_d  = min_q;
        dcnt_d = dcnt_q;
        run_d  = run_q;
        ovr_d  = ovr_q;
        to_d   = to_q;
        for (int c = 0; c < NCH; c++) begin
            // A done edge closes the running measurement; a start edge in the
            // same cycle is handled below and simply opens the next one.
            if (run_q[c] && done_e[c]) begin
                last_d[c] = cnt_q[c];
                if (cnt_q[c] > max_q[c]) max_d[c] = cnt_q[c];
                if (cnt_q[c] < min_q[c]) min_d[c] = cnt_q[c];
                if (dcnt_q[c] != '1) dcnt_d[c] = dcnt_q[c] + CW'(1);
                run_d[c] = 1'b0;
            end
            if (start_e[c]) begin
                if (run_q[c] && !done_e[c]) ovr_d[c] = 1'b1;
                cnt_d[c] = CW'(1);
                run_d[c] = 1'b1;
            end else if (run_q[c] && !done_e[c] && cnt_q[c] != '1) begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end
`ifdef PERF_WATCH_TIMEOUT_EN
            // The flag only marks the event; the measurement keeps counting.
            if (run_q[c] && timeout_lim != '0 && cnt_q[c] == timeout_lim) begin
                to_d[c] = 1'b1;
            end
`endif
        end
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_d[c]  = '0;
                last_d[c] = '0;
                max_d[c]  = '0;
                min_d[c]  = '1;
                dcnt_d[c] = '0;
            end
            run_d = '0;
            ovr_d = '0;
            to_d  = '0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]  <= '0;
                last_q[c] <= '0;
                max_q[c]  <= '0;
                min_q[c]  <= '1;
                dcnt_q[c] <= '0;
            end
            run_q <= '0;
            ovr_q <= '0;
            to_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            max_q  <= max_d;
            min_q  <= min_d;
            dcnt_q <= dcnt_d;
            run_q  <= run_d;
            ovr_q  <= ovr_d;
            to_q   <= to_d;
        end
    end

    assign timeout_flag = to_q;
    assign overrun_flag = ovr_q;

    // Registered read mux; a select beyond NCH shows the cleared values.
    logic [CW-1:0] rd_last_q, rd_max_q, rd_min_q, rd_dcnt_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_last_q <= '0;
            rd_max_q  <= '0;
            rd_min_q  <= '1;
            rd_dcnt_q <= '0;
        end else if (32'(rd_ch) < NCH) begin
            rd_last_q <= last_q[rd_ch];
            rd_max_q  <= max_q[rd_ch];
            rd_min_q  <= min_q[rd_ch];
            rd_dcnt_q <= dcnt_q[rd_ch];
        end else begin
            rd_last_q <= '0;
            rd_max_q  <= '0;
            rd_min_q  <= '1;
            rd_dcnt_q <= '0;
        end
    end

    assign lat_last = rd_last_q;
    assign lat_max  = rd_max_q;
    assign lat_min  = rd_min_q;
    assign done_cnt = rd_dcnt_q;

    // Burst engine.
    state_t          state_q, state_d;
    logic [NW-1:0]   num_q, num_d;
    logic [NW-1:0]   issued_q, issued_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic            done_sel;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            num_q    <= '0;
            issued_q <= '0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            ch_q     <= ch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        issued_d = issued_q;
        ch_d     = ch_q;
        kick     = '0;
        done_sel = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (CHW'(c) == ch_q) done_sel = done_e[c];
        end
        case (state_q)
            IDLE: begin
                if (go_e && burst_num != '0) begin
                    state_d  = KICK;
                    num_d    = burst_num;
                    ch_d     = burst_ch;
                    issued_d = '0;
                end
            end
            KICK: begin
                for (int c = 0; c < NCH; c++) begin
                    if (CHW'(c) == ch_q) kick[c] = 1'b1;
                end
                issued_d = issued_q + NW'(1);
                state_d  = WAIT;
            end
            WAIT: begin
                if (done_sel) state_d = (issued_q < num_q) ? KICK : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d  = IDLE;
            issued_d = '0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: doc/perf_watch.md
PERF_WATCH -- requirements
Module: perf_watch

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored start/done channels (1..16).
REQ-002 SHALL have parameter CW, default 32, latency counter and statistic width.
REQ-003 SHALL have parameter NW, default 16, burst count width.
REQ-004 SHALL have port ap_clk  in  1  clock; all logic rising-edge.
REQ-005 SHALL have port ap_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ap_start  in  NCH  per-channel start, asynchronous level.
REQ-007 SHALL have port ap_done  in  NCH  per-channel done, asynchronous level.
REQ-008 SHALL have port burst_go  in  1  burst request, asynchronous level, acts on rising edge.
REQ-009 SHALL have port burst_num  in  NW  kicks per burst, sampled on accepted burst_go edge.
REQ-010 SHALL have port burst_ch  in  clog2(NCH) (min 1)  burst target channel, sampled with burst_num.
REQ-011 SHALL have port clr  in  1  synchronous clear of statistics, sticky flags and burst FSM.
REQ-012 SHALL have port timeout_lim  in  CW  timeout threshold; 0 disables timeout.
REQ-013 SHALL have port rd_ch  in  clog2(NCH) (min 1)  statistics read select.
REQ-014 SHALL have port kick  out  NCH  one-cycle launch pulse per channel.
REQ-015 SHALL have port busy  out  1  burst FSM not IDLE.
REQ-016 SHALL have ports lat_last/lat_max/lat_min  out  CW each  statistics of channel rd_ch.
REQ-017 SHALL have port done_cnt  out  CW  completed measurements of channel rd_ch.
REQ-018 SHALL have ports timeout_flag, overrun_flag  out  NCH each  sticky per-channel flags.

Function
REQ-019 SHALL pass ap_start, ap_done, burst_go through three flops each; rising edge = stage1 & ~stage2 (2-cycle sync latency).
REQ-020 Per channel, SHALL on start edge load cnt=1, running=1; while running, cnt +1 per cycle, saturating at all-ones.
REQ-021 On done edge with running=1, SHALL: lat_last<=cnt, lat_max<=max(lat_max,cnt), lat_min<=min(lat_min,cnt), done_cnt+1 (saturating), running=0.
REQ-022 Done edge with running=0 SHALL be ignored.
REQ-023 Start and done edges in the same cycle SHALL close the current measurement (REQ-021) and begin a new one with cnt=1.
REQ-024 Start edge while running without done edge SHALL restart cnt=1, discard old measurement, set overrun_flag[ch].
REQ-025 Timeout: running, timeout_lim!=0, cnt==timeout_lim SHALL set timeout_flag[ch]; measurement continues.
REQ-026 Read mux SHALL be registered: outputs reflect rd_ch and stored values one cycle after change.
REQ-027 Burst FSM states IDLE, KICK, WAIT: IDLE->KICK on burst_go edge with burst_num!=0 (latch num/ch, issued=0); burst_num==0 stays IDLE.
REQ-028 KICK SHALL drive kick[burst_ch]=1 for exactly one cycle, issued+1, then go to WAIT.
REQ-029 WAIT SHALL, on done edge of burst_ch, go to KICK if issued<num, else IDLE; burst_go edges outside IDLE ignored.
REQ-030 clr SHALL, synchronously and with priority over all events: zero lat_last, lat_max, done_cnt, cnt, running, flags; set lat_min all-ones; force FSM IDLE.

Reset
REQ-031 ap_rst SHALL asynchronously clear all sync flops, counters, running bits, flags, kick, busy, lat_last, lat_max, done_cnt to 0, set lat_min to all-ones, FSM to IDLE.
REQ-032 Reset mid-burst SHALL abort with no further kick after release until a new burst_go edge.

Configuration
REQ-033 Macro PERF_WATCH_TIMEOUT_EN defined: REQ-025 logic present; undefined: timeout_flag tied 0, timeout_lim unused, all else identical.

Verification
REQ-034 NCH=4: start ch2 edge, done 10 cycles later -> lat_last=lat_max=lat_min=10, done_cnt=1 on rd_ch=2.
REQ-035 ch0 latencies 7, 3, 12 -> lat_max=12, lat_min=3, lat_last=12, done_cnt=3.
REQ-036 burst_go, burst_num=3, burst_ch=1, done fed 5 cycles after each kick -> exactly 3 one-cycle kick[1] pulses, busy low after third done.
REQ-037 timeout_lim=20, done at 25 (macro on) -> timeout_flag[0]=1, lat_last=25; macro off -> flag stays 0.
REQ-038 start edge at cnt=4 while running -> overrun_flag set, cnt=1; same-cycle start+done -> stats updated and cnt=1.
REQ-039 ap_rst asserted mid-burst and mid-measurement -> all outputs reset values, lat_min all-ones, no kick after release.
